if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, address/instruction width in bits.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  decode not accepting; hold IF output buffer.
REQ-006 redirect_valid  input  1  branch/jump resolved taken this cycle.
REQ-007 redirect_pc  input  WIDTH  branch/jump target.
REQ-008 trap_valid  input  1  exception/trap redirect this cycle.
REQ-009 trap_pc  input  WIDTH  trap handler address.
REQ-010 imem_req_valid  output  1  fetch request valid.
REQ-011 imem_req_addr  output  WIDTH  fetch address; equals pc_out.
REQ-012 imem_req_ready  input  1  memory accepts request.
REQ-013 imem_rsp_valid  input  1  instruction return valid, one cycle pulse.
REQ-014 imem_rsp_data  input  WIDTH  returned instruction.
REQ-015 pc_out  output  WIDTH  current fetch PC register.
REQ-016 if_valid  output  1  IF output buffer holds an instruction.
REQ-017 if_pc  output  WIDTH  PC of buffered instruction.
REQ-018 if_instr  output  WIDTH  buffered instruction.

Function
REQ-019 FSM states BOOT, REQ, WAIT_RSP, DRAIN; one outstanding request max.
REQ-020 BOOT: imem_req_valid=0; unconditionally -> REQ next cycle.
REQ-021 REQ: imem_req_valid = no redirect this cycle AND (!if_valid OR !stall); valid&ready -> WAIT_RSP.
REQ-022 REQ: imem_req_addr stable while valid and not ready, except on redirect.
REQ-023 WAIT_RSP, rsp_valid, no redirect: buffer <= {1, pc_out, rsp_data}; pc_out <= pc_out+4 (mod 2^WIDTH, wraps); -> REQ.
REQ-024 Redirect target = trap_pc if trap_valid else redirect_pc; trap has priority when both asserted.
REQ-025 Target bits [1:0] forced to 0 when loaded into pc_out.
REQ-026 Redirect in BOOT or REQ: pc_out <= target; -> REQ; no handshake that cycle (imem_req_valid=0).
REQ-027 Redirect in WAIT_RSP without rsp_valid: pc_out <= target; -> DRAIN.
REQ-028 Redirect in WAIT_RSP with rsp_valid same cycle: response discarded; pc_out <= target; -> REQ.
REQ-029 DRAIN: imem_req_valid=0; rsp_valid -> discard, -> REQ; further redirect updates pc_out, stays DRAIN.
REQ-030 Any redirect clears if_valid the same edge; discarded responses never reach buffer.
REQ-031 Buffer consumed on any cycle with if_valid=1 and stall=0; if_valid <= 0 unless refilled same edge.
REQ-032 stall never blocks an outstanding response; buffer is guaranteed empty on response arrival by REQ-021.
REQ-033 Back-to-back throughput: one instruction per two cycles with zero-latency memory.

Reset
REQ-034 reset_n=0 at edge: state=BOOT, pc_out=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
REQ-035 imem_req_valid=0 throughout reset and in BOOT.
REQ-036 Reset mid-transaction abandons outstanding request; a late rsp_valid in BOOT is ignored.

Structure
REQ-037 Shared pipeline package holds fetch_state_t enum and INSTR_BYTES=4 constant.
REQ-038 One sub-module if_buffer: single-entry valid/pc/instr register with load, consume, flush.
REQ-039 FSM, PC register and next-PC mux reside in if_fetch_ctrl.

Verification
REQ-040 Reset, ready=1, 1-cycle rsp -> addrs 0x0,0x4,0x8 issued in order; if_pc matches; if_valid 1 cycle after each rsp.
REQ-041 ready=0 for 3 cycles in REQ -> imem_req_addr constant, imem_req_valid held 1, one handshake.
REQ-042 redirect_valid pc=0x100 in WAIT_RSP, rsp 2 cycles later -> rsp discarded, if_valid=0, next addr 0x100.
REQ-043 trap_valid pc=0x80 and redirect_valid pc=0x200 same cycle -> next addr 0x80; target 0x203 -> 0x200.
REQ-044 stall=1 with if_valid=1 -> if_pc/if_instr unchanged, no new request until stall=0.
REQ-045 RESET_PC=0xFFFFFFFC, one fetch -> next addr 0x00000000 (wrap).

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
package if_fetch_ctrl_pkg;

  // Fetch controller states. At most one memory request is outstanding.
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DRAIN    = 2'd3
  } fetch_state_t;

  // Size of one instruction in bytes; sequential fetch advances by this.
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/if_fetch_ctrl_buffer.sv
// Single-entry IF output buffer: holds one fetched instruction and its PC
// until decode takes it. A flush wins over a load and over a consume.
module if_buffer
  import if_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  input  logic [WIDTH-1:0] load_instr,
  input  logic             consume,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr
);

  // Buffer entry update: flush empties, load fills, consume empties.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues one request at a time to the
// instruction memory, buffers the returned instruction for decode and
// handles branch/trap redirects, draining any stale in-flight response.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_pc,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic [WIDTH-1:0] pc_out,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr
);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [WIDTH-1:0] pc_next;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] target_aligned;
  logic             buf_load;
  logic             buf_consume;

  // Redirect source select: a trap overrides a branch in the same cycle.
  always_comb begin
    redirect       = trap_valid | redirect_valid;
    target         = trap_valid ? trap_pc : redirect_pc;
    target_aligned = {target[WIDTH-1:2], 2'b00};
  end

  // Next-state, next-PC and request logic for the fetch FSM.
  always_comb begin
    state_next     = state;
    pc_next        = pc_out;
    imem_req_valid = 1'b0;
    buf_load       = 1'b0;
    case (state)
      BOOT: begin
        state_next = REQ;
        if (redirect) pc_next = target_aligned;
      end
      REQ: begin
        imem_req_valid = !redirect && (!if_valid || !stall);
        if (redirect) begin
          pc_next = target_aligned;
        end else if (imem_req_valid && imem_req_ready) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (redirect) begin
          pc_next    = target_aligned;
          state_next = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          buf_load   = 1'b1;
          pc_next    = pc_out + WIDTH'(INSTR_BYTES);
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (redirect) pc_next = target_aligned;
        if (imem_rsp_valid) state_next = REQ;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= BOOT;
      pc_out <= RESET_PC;
    end else begin
      state  <= state_next;
      pc_out <= pc_next;
    end
  end

  assign imem_req_addr = pc_out;
  assign buf_consume   = if_valid && !stall;

  if_buffer #(
    .WIDTH(WIDTH)
  ) u_if_buffer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (buf_load),
    .load_pc    (pc_out),
    .load_instr (imem_rsp_data),
    .consume    (buf_consume),
    .flush      (redirect),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl. A second instance with RESET_PC at
// the top of the address space shares the stimulus to exercise PC wrap.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] pc_out;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic [31:0] w_pc_out;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc_out(pc_out), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  if_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc_out(w_pc_out), .if_valid(w_if_valid),
    .if_pc(w_if_pc), .if_instr(w_if_instr)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst_n, input logic stl,
                               input logic rv, input logic [31:0] rpc,
                               input logic tv, input logic [31:0] tpc,
                               input logic rdy, input logic rspv,
                               input logic [31:0] rspd);
    reset_n        = rst_n;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    trap_valid     = tv;
    trap_pc        = tpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    #1;
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    // Reset values
    checkOutput("rst_pc_out", pc_out, 32'h0);
    checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("rst_wrap_pc", w_pc_out, 32'hFFFF_FFFC);

    // Sequential fetch 0x0, 0x4, 0x8 with zero-latency memory
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("boot_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    checkOutput("req0_valid", {31'b0, imem_req_valid}, 32'h1);
    checkOutput("req0_addr", imem_req_addr, 32'h0);
    checkOutput("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h1111_1111);
    checkOutput("wait_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    checkOutput("rsp0_if_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("rsp0_if_pc", if_pc, 32'h0);
    checkOutput("rsp0_if_instr", if_instr, 32'h1111_1111);
    checkOutput("wrap_pc_out", w_pc_out, 32'h0);
    checkOutput("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("req1_addr", imem_req_addr, 32'h4);
    checkOutput("req1_valid", {31'b0, imem_req_valid}, 32'h1);
    tick();
    checkOutput("consumed_if_valid", {31'b0, if_valid}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h2222_2222);
    tick();
    checkOutput("rsp1_if_pc", if_pc, 32'h4);
    checkOutput("rsp1_if_instr", if_instr, 32'h2222_2222);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("req2_addr", imem_req_addr, 32'h8);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h3333_3333);
    tick();
    checkOutput("rsp2_if_pc", if_pc, 32'h8);
    checkOutput("rsp2_if_instr", if_instr, 32'h3333_3333);
    checkOutput("pc_after_3", pc_out, 32'hC);

    // Stall holds the buffer and suppresses new requests
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    tick();
    checkOutput("stall_if_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("stall_if_pc", if_pc, 32'h8);
    checkOutput("stall_if_instr", if_instr, 32'h3333_3333);
    checkOutput("stall_req_valid2", {31'b0, imem_req_valid}, 32'h0);

    // Memory not ready for 3 cycles: address and valid held
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("notrdy_valid%0d", i), {31'b0, imem_req_valid}, 32'h1);
      checkOutput($sformatf("notrdy_addr%0d", i), imem_req_addr, 32'hC);
      tick();
    end
    checkOutput("notrdy_if_valid", {31'b0, if_valid}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("one_handshake", {31'b0, imem_req_valid}, 32'h0);

    // Redirect in WAIT_RSP, response arrives two cycles later and is dropped
    applyStimulus(1, 0, 1, 32'h100, 0, 0, 1, 0, 0);
    tick();
    checkOutput("drain_pc_out", pc_out, 32'h100);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("drain_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("drop_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("redir_addr", imem_req_addr, 32'h100);
    checkOutput("redir_req_valid", {31'b0, imem_req_valid}, 32'h1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h4444_4444);
    tick();
    checkOutput("redir_if_pc", if_pc, 32'h100);
    checkOutput("redir_if_instr", if_instr, 32'h4444_4444);

    // Trap beats branch; redirect target low bits cleared
    applyStimulus(1, 1, 1, 32'h200, 1, 32'h80, 1, 0, 0);
    checkOutput("trap_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    checkOutput("trap_pc_out", pc_out, 32'h80);
    checkOutput("trap_flush", {31'b0, if_valid}, 32'h0);
    applyStimulus(1, 0, 1, 32'h203, 0, 0, 1, 0, 0);
    tick();
    checkOutput("align_pc_out", pc_out, 32'h200);

    // Redirect coinciding with a response: response dropped
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 32'h300, 0, 0, 1, 1, 32'h5555_5555);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("same_cyc_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("same_cyc_addr", imem_req_addr, 32'h300);
    checkOutput("same_cyc_req_valid", {31'b0, imem_req_valid}, 32'h1);

    // Reset mid-transaction; a late response in BOOT is ignored
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h6666_6666);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("late_rsp_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("late_rsp_pc_out", pc_out, 32'h0);
    checkOutput("late_rsp_req_valid", {31'b0, imem_req_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
